// File: rtl/reg_file_mp.sv
// Multi-port register file: two combinational read ports with write bypass,
// two write ports (port 1 wins), and a per-register pending-writer scoreboard.
module reg_file_mp #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            we0,
    input  logic [AW-1:0]   wa0,
    input  logic [XLEN-1:0] wd0,
    input  logic            we1,
    input  logic [AW-1:0]   wa1,
    input  logic [XLEN-1:0] wd1,
    input  logic            alloc_en,
    input  logic [AW-1:0]   alloc_rd,
    output logic [AW:0]     pending_cnt
);

    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;

    logic wr0_ok, wr1_ok, alloc_ok;
    logic hit1_a, hit0_a, hit1_b, hit0_b;

    assign wr0_ok   = we0 && (wa0 != '0);
    assign wr1_ok   = we1 && (wa1 != '0);
    assign alloc_ok = alloc_en && (alloc_rd != '0);

    // Allocation is applied after the write clears so a new producer keeps the bit set.
    always_comb begin
        busy_next = busy;
        if (wr0_ok)   busy_next[wa0]      = 1'b0;
        if (wr1_ok)   busy_next[wa1]      = 1'b0;
        if (alloc_ok) busy_next[alloc_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr0_ok) regs[wa0] <= wd0;
            if (wr1_ok) regs[wa1] <= wd1;
            busy <= busy_next;
        end
    end

    assign hit1_a = wr1_ok && (wa1 == rs1_addr);
    assign hit0_a = wr0_ok && (wa0 == rs1_addr);
    assign hit1_b = wr1_ok && (wa1 == rs2_addr);
    assign hit0_b = wr0_ok && (wa0 == rs2_addr);

    always_comb begin
        rs1_data = '0;
        if (rs1_addr != '0) begin
            if (hit1_a)      rs1_data = wd1;
            else if (hit0_a) rs1_data = wd0;
            else             rs1_data = regs[rs1_addr];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr != '0) begin
            if (hit1_b)      rs2_data = wd1;
            else if (hit0_b) rs2_data = wd0;
            else             rs2_data = regs[rs2_addr];
        end
    end

    // A same-cycle write to the operand retires the pending writer for the reader.
    assign rs1_busy = busy[rs1_addr] && !(hit1_a || hit0_a);
    assign rs2_busy = busy[rs2_addr] && !(hit1_b || hit0_b);

    always_comb begin
        pending_cnt = '0;
        for (int i = 0; i < NREGS; i++) begin
            pending_cnt = pending_cnt + {{AW{1'b0}}, busy[i]};
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_reg_file_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [AW-1:0]   rs1_addr = '0, rs2_addr = '0;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            rs1_busy, rs2_busy;
    logic            we0 = 1'b0, we1 = 1'b0, alloc_en = 1'b0;
    logic [AW-1:0]   wa0 = '0, wa1 = '0, alloc_rd = '0;
    logic [XLEN-1:0] wd0 = '0, wd1 = '0;
    logic [AW:0]     pending_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .alloc_en(alloc_en), .alloc_rd(alloc_rd),
        .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge();
        if (rst) begin
            model_reset();
        end else begin
            if (we0 && wa0 != 0) begin m_regs[wa0] = wd0; m_busy[wa0] = 1'b0; end
            if (we1 && wa1 != 0) begin m_regs[wa1] = wd1; m_busy[wa1] = 1'b0; end
            if (alloc_en && alloc_rd != 0) m_busy[alloc_rd] = 1'b1;
        end
    endfunction

    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (we1 && wa1 == a) return wd1;
        if (we0 && wa0 == a) return wd0;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if ((we1 && wa1 == a) || (we0 && wa0 == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [AW:0] exp_cnt();
        int c = 0;
        for (int i = 0; i < NREGS; i++) c += int'(m_busy[i]);
        return c[AW:0];
    endfunction

    task automatic idle();
        we0 = 0; we1 = 0; alloc_en = 0;
        wa0 = '0; wa1 = '0; alloc_rd = '0; wd0 = '0; wd1 = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
        for (int a = 0; a < NREGS; a++) begin
            rs1_addr = a[AW-1:0];
            rs2_addr = 5'(NREGS - 1 - a);
            #1;
            n_checks++;
            if (rs1_data !== '0) begin n_fail++; $display("FAIL reset_rs1 addr %0d: got %h expected 0", a, rs1_data); end
            n_checks++;
            if (rs2_data !== '0) begin n_fail++; $display("FAIL reset_rs2 addr %0d: got %h expected 0", NREGS - 1 - a, rs2_data); end
        end
        n_checks++;
        if (pending_cnt !== 0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", pending_cnt); end
    endtask

    task automatic test_bypass();
        idle();
        we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; rs1_addr = 5;
        #1;
        n_checks++;
        if (rs1_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_same_cycle: got %h expected deadbeef", rs1_data); end
        tick();
        idle();
        #1;
        n_checks++;
        if (rs1_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_stored: got %h expected deadbeef", rs1_data); end
    endtask

    task automatic test_write_priority();
        idle();
        we0 = 1; wa0 = 7; wd0 = 32'h11;
        we1 = 1; wa1 = 7; wd1 = 32'h22;
        rs1_addr = 7; rs2_addr = 7;
        #1;
        n_checks++;
        if (rs2_data !== 32'h22) begin n_fail++; $display("FAIL prio_bypass: got %h expected 22", rs2_data); end
        tick();
        idle();
        #1;
        n_checks++;
        if (rs1_data !== 32'h22) begin n_fail++; $display("FAIL prio_stored: got %h expected 22", rs1_data); end
    endtask

    task automatic test_zero_reg();
        logic [AW:0] cnt_before;
        idle();
        cnt_before = exp_cnt();
        we1 = 1; wa1 = 0; wd1 = 32'hFFFF_FFFF; rs2_addr = 0;
        #1;
        n_checks++;
        if (rs2_data !== '0) begin n_fail++; $display("FAIL zero_bypass: got %h expected 0", rs2_data); end
        tick();
        idle();
        alloc_en = 1; alloc_rd = 0;
        tick();
        idle();
        #1;
        n_checks++;
        if (rs2_data !== '0) begin n_fail++; $display("FAIL zero_stored: got %h expected 0", rs2_data); end
        n_checks++;
        if (pending_cnt !== cnt_before) begin n_fail++; $display("FAIL zero_cnt: got %0d expected %0d", pending_cnt, cnt_before); end
        n_checks++;
        if (rs2_busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b expected 0", rs2_busy); end
    endtask

    task automatic test_alloc();
        idle();
        alloc_en = 1; alloc_rd = 3; rs1_addr = 3;
        #1;
        n_checks++;
        if (rs1_busy !== 1'b0 || pending_cnt !== 0) begin n_fail++; $display("FAIL alloc_early: got busy=%b cnt=%0d expected busy=0 cnt=0", rs1_busy, pending_cnt); end
        tick();
        idle();
        #1;
        n_checks++;
        if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL alloc_busy: got %b expected 1", rs1_busy); end
        n_checks++;
        if (pending_cnt !== 1) begin n_fail++; $display("FAIL alloc_cnt: got %0d expected 1", pending_cnt); end
        we0 = 1; wa0 = 3; wd0 = 32'h55;
        #1;
        n_checks++;
        if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL alloc_bypass_busy: got %b expected 0", rs1_busy); end
        n_checks++;
        if (rs1_data !== 32'h55) begin n_fail++; $display("FAIL alloc_bypass_data: got %h expected 55", rs1_data); end
        tick();
        idle();
        #1;
        n_checks++;
        if (pending_cnt !== 0) begin n_fail++; $display("FAIL alloc_retire_cnt: got %0d expected 0", pending_cnt); end
    endtask

    task automatic test_alloc_write_same();
        idle();
        alloc_en = 1; alloc_rd = 9;
        we1 = 1; wa1 = 9; wd1 = 32'h77;
        rs1_addr = 9;
        tick();
        idle();
        #1;
        n_checks++;
        if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL same_busy: got %b expected 1", rs1_busy); end
        n_checks++;
        if (rs1_data !== 32'h77) begin n_fail++; $display("FAIL same_data: got %h expected 77", rs1_data); end
        n_checks++;
        if (pending_cnt !== 1) begin n_fail++; $display("FAIL same_cnt: got %0d expected 1", pending_cnt); end
    endtask

    task automatic test_async_reset();
        // Currently mid-cycle after the previous tick, well before the next edge.
        rst = 1;
        model_reset();
        #1;
        n_checks++;
        if (rs1_data !== '0) begin n_fail++; $display("FAIL async_data: got %h expected 0", rs1_data); end
        n_checks++;
        if (pending_cnt !== 0 || rs1_busy !== 1'b0) begin n_fail++; $display("FAIL async_busy: got cnt=%0d busy=%b expected 0/0", pending_cnt, rs1_busy); end
        we0 = 1; wa0 = 9; wd0 = 32'hABC;
        #1;
        n_checks++;
        if (rs1_data !== 32'hABC) begin n_fail++; $display("FAIL reset_bypass: got %h expected abc", rs1_data); end
        we0 = 0;
        #1;
        n_checks++;
        if (rs1_data !== '0) begin n_fail++; $display("FAIL reset_state: got %h expected 0", rs1_data); end
        rst = 0;
    endtask

    task automatic test_reset_ignores_edge();
        idle();
        rst = 1;
        we0 = 1; wa0 = 4; wd0 = 32'h1234;
        alloc_en = 1; alloc_rd = 4;
        tick();
        rst = 0;
        idle();
        rs1_addr = 4;
        #1;
        n_checks++;
        if (rs1_data !== '0 || rs1_busy !== 1'b0) begin n_fail++; $display("FAIL reset_edge: got data=%h busy=%b expected 0/0", rs1_data, rs1_busy); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            we0 = $urandom_range(0, 1); we1 = $urandom_range(0, 1);
            alloc_en = $urandom_range(0, 1);
            wa0 = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom);
            wa1 = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom);
            alloc_rd = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom);
            rs1_addr = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom);
            rs2_addr = 5'($urandom);
            wd0 = $urandom; wd1 = $urandom;
            #1;
            n_checks++;
            if (rs1_data !== exp_data(rs1_addr)) begin n_fail++; $display("FAIL rand_rs1_data: got %h expected %h", rs1_data, exp_data(rs1_addr)); end
            n_checks++;
            if (rs2_data !== exp_data(rs2_addr)) begin n_fail++; $display("FAIL rand_rs2_data: got %h expected %h", rs2_data, exp_data(rs2_addr)); end
            n_checks++;
            if (rs1_busy !== exp_busy(rs1_addr)) begin n_fail++; $display("FAIL rand_rs1_busy: got %b expected %b", rs1_busy, exp_busy(rs1_addr)); end
            n_checks++;
            if (rs2_busy !== exp_busy(rs2_addr)) begin n_fail++; $display("FAIL rand_rs2_busy: got %b expected %b", rs2_busy, exp_busy(rs2_addr)); end
            n_checks++;
            if (pending_cnt !== exp_cnt()) begin n_fail++; $display("FAIL rand_cnt: got %0d expected %0d", pending_cnt, exp_cnt()); end
            tick();
        end
        idle();
    endtask

    initial begin
        model_reset();
        #2;
        test_reset();
        test_bypass();
        test_write_priority();
        test_zero_reg();
        test_alloc();
        test_alloc_write_same();
        test_async_reset();
        test_reset_ignores_edge();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
